// File: rtl/aibcr3_rambit_wr_if.sv
// Serial CSR chain and rambit configuration bundle between a chain driver and the rambit writer.
interface aibcr3_rambit_wr_if #(
    parameter int NBITS = 64
);
    logic             csr_en;
    logic             csr_in;
    logic             csr_commit;
    logic             csr_out;
    logic [NBITS-1:0] rambit_out;
    logic             cfg_rdy;
    logic             cfg_busy;
    logic             cfg_err;

    modport master (
        output csr_en,
        output csr_in,
        output csr_commit,
        input  csr_out,
        input  rambit_out,
        input  cfg_rdy,
        input  cfg_busy,
        input  cfg_err
    );

    modport slave (
        input  csr_en,
        input  csr_in,
        input  csr_commit,
        output csr_out,
        output rambit_out,
        output cfg_rdy,
        output cfg_busy,
        output cfg_err
    );
endinterface

// File: rtl/aibcr3_rambit_wr.sv
// Shifts a config frame into a shadow register and commits it atomically to the rambit outputs.
// Commit sampled at edge N is visible on rambit_out/cfg_rdy after edge N+1; no backpressure.
module aibcr3_rambit_wr #(
    parameter int NBITS = 64,
    parameter int CNTW  = 7
) (
    input  logic              csr_clk,
    input  logic              csr_rstn,
    input  logic              vcc,
    input  logic              vssl,
    aibcr3_rambit_wr_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        FULL   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NBITS);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBITS - 1);

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] shadow;
    logic [NBITS-1:0] rambit;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_next;
    logic             rdy;
    logic             err;
    logic             do_shift;
    logic             err_set;
    logic             unused_supply;

    // Supply pins carry no logic; tie them off so they are not flagged as dangling.
    assign unused_supply = vcc & vssl;

    always_ff @(posedge csr_clk) begin
        if (!csr_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.csr_en) begin
                    state_next = SHIFT;
                end else if (bus.csr_commit) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (bus.csr_en) begin
                    state_next = (count == CNT_LAST) ? FULL : SHIFT;
                end else if (bus.csr_commit) begin
                    state_next = IDLE;
                end
            end
            FULL: begin
                if (bus.csr_commit && !bus.csr_en) begin
                    state_next = COMMIT;
                end
            end
            COMMIT:  state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // A commit colliding with a shift is a protocol error; the shift still happens.
    always_comb begin
        do_shift   = 1'b0;
        err_set    = 1'b0;
        count_next = count;
        case (state)
            IDLE, DONE: begin
                if (bus.csr_en) begin
                    do_shift   = 1'b1;
                    err_set    = bus.csr_commit;
                    count_next = CNTW'(1);
                end else if (bus.csr_commit) begin
                    err_set    = 1'b1;
                    count_next = '0;
                end
            end
            SHIFT: begin
                if (bus.csr_en) begin
                    do_shift   = 1'b1;
                    err_set    = bus.csr_commit;
                    count_next = (count == CNT_FULL) ? count : count + CNTW'(1);
                end else if (bus.csr_commit) begin
                    err_set    = 1'b1;
                    count_next = '0;
                end
            end
            FULL: begin
                if (bus.csr_en) begin
                    do_shift   = 1'b1;
                    err_set    = bus.csr_commit;
                    count_next = CNT_FULL;
                end
            end
            COMMIT:  count_next = '0;
            default: count_next = '0;
        endcase
    end

    always_ff @(posedge csr_clk) begin
        if (!csr_rstn) begin
            shadow <= '0;
            count  <= '0;
            rambit <= '0;
            rdy    <= 1'b0;
            err    <= 1'b0;
        end else begin
            count <= count_next;
            if (do_shift) begin
                shadow <= {shadow[NBITS-2:0], bus.csr_in};
            end
            // Shadow is frozen during COMMIT; a shift attempted there flags an error
            // that overrides the clear from the otherwise successful commit.
            if (state == COMMIT) begin
                rambit <= shadow;
                rdy    <= 1'b1;
                err    <= bus.csr_en;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.csr_out    = shadow[NBITS-1];
    assign bus.rambit_out = rambit;
    assign bus.cfg_rdy    = rdy;
    assign bus.cfg_err    = err;
    assign bus.cfg_busy   = (state == SHIFT) || (state == FULL);

endmodule

// File: tb/tb_aibcr3_rambit_wr.sv
// Directed bench for aibcr3_rambit_wr (NBITS=8) with a queue-based scoreboard and negedge monitor.
module tb_aibcr3_rambit_wr;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] rambit;
        logic       rdy;
        logic       busy;
        logic       err;
        logic       out;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    aibcr3_rambit_wr_if #(.NBITS(8)) bus ();

    aibcr3_rambit_wr #(
        .NBITS(8),
        .CNTW (4)
    ) dut (
        .csr_clk (clk),
        .csr_rstn(rstn),
        .vcc     (1'b1),
        .vssl    (1'b0),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: sample missed, got cycle %0d want cycle %0d", e.name, cyc, e.cyc);
            end else if (e.kind == 0) begin
                if ({bus.rambit_out, bus.cfg_rdy, bus.cfg_busy, bus.cfg_err} !==
                    {e.rambit, e.rdy, e.busy, e.err}) begin
                    errors++;
                    $display("FAIL %s: got rambit=%b rdy=%b busy=%b err=%b, want rambit=%b rdy=%b busy=%b err=%b",
                             e.name, bus.rambit_out, bus.cfg_rdy, bus.cfg_busy, bus.cfg_err,
                             e.rambit, e.rdy, e.busy, e.err);
                end
            end else begin
                if (bus.csr_out !== e.out) begin
                    errors++;
                    $display("FAIL %s: got csr_out=%b want csr_out=%b", e.name, bus.csr_out, e.out);
                end
            end
        end
    end

    task automatic tick(input logic en, input logic din, input logic commit);
        bus.csr_en     = en;
        bus.csr_in     = din;
        bus.csr_commit = commit;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tick(1'b1, v[i], 1'b0);
    endtask

    task automatic expect_status(input string nm, input logic [7:0] rb, input logic rdy,
                                 input logic busy, input logic err);
        exp_t x;
        x.cyc = cyc; x.kind = 0; x.rambit = rb; x.rdy = rdy; x.busy = busy; x.err = err;
        x.out = 1'b0; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic expect_out(input string nm, input logic o);
        exp_t x;
        x.cyc = cyc; x.kind = 1; x.rambit = '0; x.rdy = 1'b0; x.busy = 1'b0; x.err = 1'b0;
        x.out = o; x.name = nm;
        sb.push_back(x);
    endtask

    logic chain_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] long_frame = 16'b0000_1101_0011_1010;

    initial begin
        bus.csr_en = 1'b0;
        bus.csr_in = 1'b0;
        bus.csr_commit = 1'b0;

        // Reset state
        rstn = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        expect_status("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        expect_out("reset_csr_out", 1'b0);
        rstn = 1'b1;

        // Commit with no frame
        tick(1'b0, 1'b0, 1'b1);
        expect_status("commit_in_idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // First full frame
        tick(1'b1, 1'b1, 1'b0);
        expect_status("first_shift_busy", 8'h00, 1'b0, 1'b1, 1'b1);
        send(16'b0110010, 7);
        expect_status("frame1_full", 8'h00, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        expect_status("frame1_commit_cycle", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        expect_status("frame1_done", 8'b10110010, 1'b1, 1'b0, 1'b0);
        expect_out("frame1_csr_out", 1'b1);

        // Short frame
        send(16'h001F, 5);
        tick(1'b0, 1'b0, 1'b1);
        expect_status("short_frame", 8'b10110010, 1'b1, 1'b0, 1'b1);
        send(16'b01101001, 8);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        expect_status("frame2_done", 8'b01101001, 1'b1, 1'b0, 1'b0);

        // Over-long frame: first four bits pass through to csr_out
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1, long_frame[12-k], 1'b0);
            if (k >= 8 && k <= 11) expect_out($sformatf("chain_bit%0d", k - 7), chain_exp[k-8]);
        end
        expect_status("long_full", 8'b01101001, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        expect_status("long_done", 8'b00111010, 1'b1, 1'b0, 1'b0);

        // Commit together with the 8th shift
        send(16'b1000000, 7);
        tick(1'b1, 1'b1, 1'b1);
        expect_status("commit_with_shift", 8'b00111010, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        expect_status("collide_recommit", 8'b10000001, 1'b1, 1'b0, 1'b0);

        // Reset during COMMIT
        send(16'b11110000, 8);
        tick(1'b0, 1'b0, 1'b1);
        rstn = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        expect_status("reset_in_commit", 8'h00, 1'b0, 1'b0, 1'b0);
        expect_out("reset_in_commit_out", 1'b0);
        rstn = 1'b1;

        // Shift attempted during COMMIT
        send(16'b01001100, 8);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        expect_status("en_in_commit", 8'b01001100, 1'b1, 1'b0, 1'b1);
        expect_out("en_in_commit_frozen", 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        expect_status("done_hold", 8'b01001100, 1'b1, 1'b0, 1'b1);

        repeat (3) tick(1'b0, 1'b0, 1'b0);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
